// File: rtl/count_source_if.sv
// Pushbutton/switch inputs and counter outputs of count_source.
// master drives buttons and switches; slave is the counter.
interface count_source_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_clr;
  logic       btn_ld;
  logic [7:0] sw;
  logic [7:0] value;
  logic       changed;

  modport master (
    output btn_up, btn_dn, btn_clr, btn_ld, sw,
    input  value, changed
  );

  modport slave (
    input  btn_up, btn_dn, btn_clr, btn_ld, sw,
    output value, changed
  );
endinterface

// File: rtl/count_source.sv
// Debounced up/down/clear/load counter; value moves DEB_CYCLES+3 clocks after a clean press, no backpressure.
// Define COUNT_SAT_EN to saturate at 0/255 instead of wrapping modulo 256.
module count_source #(
  parameter int DEB_CYCLES = 16,
  parameter int STEP       = 1
) (
  input  logic          clk,
  input  logic          rst,
  count_source_if.slave bus
);

  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_CLR = 2;
  localparam int B_LD  = 3;

  localparam logic [15:0] CNT_MAX = 16'(DEB_CYCLES - 1);
  localparam logic [7:0]  STEP_B  = 8'(STEP);

  logic [3:0]       btn_raw;
  logic [3:0]       btn_s1_q, btn_s1_d;
  logic [3:0]       btn_s2_q, btn_s2_d;
  logic [7:0]       sw_s1_q, sw_s1_d;
  logic [7:0]       sw_s2_q, sw_s2_d;
  logic [3:0][15:0] cnt_q, cnt_d;
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       deb_dly_q, deb_dly_d;
  logic [3:0]       press_q, press_d;
  logic [7:0]       value_q, value_d;
  logic             changed_q, changed_d;
  logic [7:0]       inc_val, dec_val;

  assign btn_raw = {bus.btn_ld, bus.btn_clr, bus.btn_dn, bus.btn_up};

`ifdef COUNT_SAT_EN
  logic [8:0] sum9, dif9;

  always_comb begin
    sum9    = {1'b0, value_q} + {1'b0, STEP_B};
    dif9    = {1'b0, value_q} - {1'b0, STEP_B};
    inc_val = sum9[8] ? 8'hFF : sum9[7:0];
    dec_val = dif9[8] ? 8'h00 : dif9[7:0];
  end
`else
  always_comb begin
    inc_val = value_q + STEP_B;
    dec_val = value_q - STEP_B;
  end
`endif

  always_comb begin
    btn_s1_d  = btn_raw;
    btn_s2_d  = btn_s1_q;
    sw_s1_d   = bus.sw;
    sw_s2_d   = sw_s1_q;
    cnt_d     = cnt_q;
    deb_d     = deb_q;
    value_d   = value_q;
    changed_d = 1'b0;

    // Counter only survives runs of consecutive disagreement; any agreement restarts it.
    for (int b = 0; b < 4; b++) begin
      if (btn_s2_q[b] == deb_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        deb_d[b] = ~deb_q[b];
        cnt_d[b] = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 16'd1;
      end
    end

    deb_dly_d = deb_q;
    press_d   = deb_q & ~deb_dly_q;

    if (press_q[B_CLR]) begin
      value_d   = 8'h00;
      changed_d = 1'b1;
    end else if (press_q[B_LD]) begin
      value_d   = sw_s2_q;
      changed_d = 1'b1;
    end else if (press_q[B_UP] && !press_q[B_DN]) begin
      value_d   = inc_val;
      changed_d = 1'b1;
    end else if (press_q[B_DN] && !press_q[B_UP]) begin
      value_d   = dec_val;
      changed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      cnt_q     <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      press_q   <= '0;
      value_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      press_q   <= press_d;
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_count_source.sv
// Bench for count_source: STEP=1 and STEP=10 instances share stimulus; a history-based
// model (raw sample log, DEB-long agreement windows) predicts value/changed every clock.
module tb_count_source;

  localparam int DEB  = 4;
  localparam int NCYC = 4096;

`ifdef COUNT_SAT_EN
  localparam int EXP_UP10 = 255;
  localparam int EXP_DN10 = 0;
`else
  localparam int EXP_UP10 = 4;
  localparam int EXP_DN10 = 249;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [7:0] sw;

  count_source_if bus0 ();
  count_source_if bus1 ();

  assign bus0.btn_up  = btn[0];
  assign bus0.btn_dn  = btn[1];
  assign bus0.btn_clr = btn[2];
  assign bus0.btn_ld  = btn[3];
  assign bus0.sw      = sw;
  assign bus1.btn_up  = btn[0];
  assign bus1.btn_dn  = btn[1];
  assign bus1.btn_clr = btn[2];
  assign bus1.btn_ld  = btn[3];
  assign bus1.sw      = sw;

  count_source #(.DEB_CYCLES(DEB), .STEP(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  count_source #(.DEB_CYCLES(DEB), .STEP(10)) u_dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  int chg_cnt;

  // Reference history: what each edge sampled, with reset edges logged as 0.
  bit         rst_h  [NCYC];
  bit         raw_h  [4][NCYC];
  bit         rise_h [4][NCYC];
  logic [7:0] sw_h   [NCYC];
  bit         deb_m  [4];
  bit [3:0]   evt_m;
  int         mv     [2];
  int         mchg   [2];
  int         steps  [2] = '{1, 10};

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Level the logic sees at edge j: raw sampled two edges earlier, unless reset intervened.
  function automatic bit sync_lvl(int b, int j);
    if (j < 2) return 1'b0;
    if (rst_h[j-1]) return 1'b0;
    return raw_h[b][j-2];
  endfunction

  function automatic logic [7:0] sw_lvl(int j);
    if (j < 2) return 8'h00;
    if (rst_h[j-1]) return 8'h00;
    return sw_h[j-2];
  endfunction

  function automatic int add_step(int v, int s);
    int r = v + s;
`ifdef COUNT_SAT_EN
    if (r > 255) r = 255;
`else
    if (r > 255) r = r - 256;
`endif
    return r;
  endfunction

  function automatic int sub_step(int v, int s);
    int r = v - s;
`ifdef COUNT_SAT_EN
    if (r < 0) r = 0;
`else
    if (r < 0) r = r + 256;
`endif
    return r;
  endfunction

  task automatic model_edge();
    bit [3:0] new_evt;
    bit       ok;
    rst_h[k] = rst;
    sw_h[k]  = rst ? 8'h00 : sw;
    for (int b = 0; b < 4; b++) raw_h[b][k] = rst ? 1'b0 : btn[b];

    for (int b = 0; b < 4; b++) begin
      new_evt[b]   = !rst && (k >= 1) && rise_h[b][k-1];
      rise_h[b][k] = 1'b0;
      if (rst) begin
        deb_m[b] = 1'b0;
      end else begin
        ok = 1'b1;
        for (int i = 0; i < DEB; i++) begin
          if ((k - i) < 0) ok = 1'b0;
          else if (rst_h[k-i] || (sync_lvl(b, k - i) == deb_m[b])) ok = 1'b0;
        end
        if (ok) begin
          deb_m[b]     = !deb_m[b];
          rise_h[b][k] = deb_m[b];
        end
      end
    end

    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        mv[n]   = 0;
        mchg[n] = 0;
      end else begin
        mchg[n] = 1;
        if (evt_m[2])                  mv[n] = 0;
        else if (evt_m[3])             mv[n] = int'(sw_lvl(k));
        else if (evt_m[0] && !evt_m[1]) mv[n] = add_step(mv[n], steps[n]);
        else if (evt_m[1] && !evt_m[0]) mv[n] = sub_step(mv[n], steps[n]);
        else                           mchg[n] = 0;
      end
    end
    evt_m = new_evt;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (k >= NCYC) begin
        $display("FAIL hist_overflow: edge %0d limit %0d", k, NCYC);
        $fatal(1);
      end
      model_edge();
      k++;
      @(negedge clk);
      check("value_s1",    int'(bus0.value),   mv[0]);
      check("changed_s1",  int'(bus0.changed), mchg[0]);
      check("value_s10",   int'(bus1.value),   mv[1]);
      check("changed_s10", int'(bus1.changed), mchg[1]);
      if (bus0.changed) chg_cnt++;
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step(10);
    btn = 4'b0000;
    step(10);
  endtask

  initial begin
    rst     = 1'b1;
    btn     = 4'b0000;
    sw      = 8'h00;
    chg_cnt = 0;
    evt_m   = '0;
    mv      = '{0, 0};
    mchg    = '{0, 0};
    for (int b = 0; b < 4; b++) deb_m[b] = 1'b0;

    step(3);
    check("rst_value",   int'(bus0.value),   0);
    check("rst_changed", int'(bus0.changed), 0);

    // Held press: update exactly 7 edges after the first high sample, single pulse.
    rst     = 1'b0;
    btn     = 4'b0001;
    chg_cnt = 0;
    step(7);
    check("lat_before", int'(bus0.value), 0);
    step(1);
    check("lat_value",   int'(bus0.value),   1);
    check("lat_changed", int'(bus0.changed), 1);
    step(1);
    check("lat_pulse_end", int'(bus0.changed), 0);
    step(11);
    check("held_value", int'(bus0.value), 1);
    check("held_pulses", chg_cnt, 1);
    btn = 4'b0000;
    step(10);

    // Short glitches on dn are filtered; bring value back to 0 first.
    press(4'b0100);
    chg_cnt = 0;
    for (int w = 1; w <= 3; w++) begin
      btn = 4'b0010;
      step(w);
      btn = 4'b0000;
      step(10);
    end
    check("glitch_value", int'(bus0.value), 0);
    check("glitch_pulses", chg_cnt, 0);

    // ld beats up in the same cycle; up+dn together cancel.
    sw = 8'hC8;
    step(3);
    chg_cnt = 0;
    press(4'b1001);
    check("ld_up_value_s1",  int'(bus0.value), 200);
    check("ld_up_value_s10", int'(bus1.value), 200);
    check("ld_up_pulses", chg_cnt, 1);
    chg_cnt = 0;
    press(4'b0011);
    check("updn_value", int'(bus0.value), 200);
    check("updn_pulses", chg_cnt, 0);

    // Overflow / underflow with STEP=10 next to STEP=1.
    sw = 8'd250;
    step(3);
    press(4'b1000);
    check("ld250", int'(bus1.value), 250);
    press(4'b0001);
    check("up_over_s1",  int'(bus0.value), 251);
    check("up_over_s10", int'(bus1.value), EXP_UP10);
    sw = 8'd3;
    step(3);
    press(4'b1000);
    press(4'b0010);
    check("dn_under_s1",  int'(bus0.value), 2);
    check("dn_under_s10", int'(bus1.value), EXP_DN10);

    // clr at zero still pulses changed.
    press(4'b0100);
    chg_cnt = 0;
    press(4'b0100);
    check("clr0_value", int'(bus0.value), 0);
    check("clr0_pulses", chg_cnt, 1);

    // Reset mid-debounce kills the pending press.
    btn = 4'b0001;
    step(4);
    rst = 1'b1;
    btn = 4'b0000;
    step(2);
    rst     = 1'b0;
    chg_cnt = 0;
    step(15);
    check("rst_mid_value", int'(bus0.value), 0);
    check("rst_mid_pulses", chg_cnt, 0);
    press(4'b0001);
    check("repress_value", int'(bus0.value), 1);

    // Button held through reset counts as a fresh press after release of reset.
    btn = 4'b0001;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(7);
    check("held_rst_before", int'(bus0.value), 0);
    step(1);
    check("held_rst_value", int'(bus0.value), 1);
    btn = 4'b0000;
    step(10);

    // Random presses, glitches, switch changes and occasional resets.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      for (int b = 0; b < 4; b++) btn[b] = ($urandom_range(0, 2) == 0);
      step($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 0) begin
        btn = 4'b0000;
        step($urandom_range(1, 8));
      end
    end
    btn = 4'b0000;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
